// File: rtl/sram2_pkg.sv
// rtl/sram2_pkg.sv - shared constants and types for the SRAM2 arbiter
package sram2_pkg;

  localparam logic [31:0] SRAM2_BASE  = 32'h1000_0000;
  localparam logic [31:0] SRAM2_LIMIT = 32'h1000_7FFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic M_FETCH = 1'b0;
  localparam logic M_LSU   = 1'b1;

endpackage

// File: rtl/sram2_parity_gen.sv
// rtl/sram2_parity_gen.sv - even parity per byte for the SRAM2 write word
module sram2_parity_gen (
  input  logic [31:0] data,
  output logic [3:0]  parity
);

  // Bit k covers byte k, matching the SRAM2 parity checker's ordering.
  assign parity[0] = ^data[7:0];
  assign parity[1] = ^data[15:8];
  assign parity[2] = ^data[23:16];
  assign parity[3] = ^data[31:24];

endmodule

// File: rtl/sram2_arbiter.sv
// rtl/sram2_arbiter.sv - two-master round-robin arbiter for the single-ported SRAM2
module sram2_arbiter
  import sram2_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = SRAM2_BASE,
  parameter logic [31:0] LIMIT_ADDR = SRAM2_LIMIT,
  parameter logic [31:0] IDLE_ADDR  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_write,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_write,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,
  output logic        sram_write_enable,
  output logic [31:0] sram_address,
  output logic [35:0] sram_data_in,
  input  logic [31:0] sram_data_out,
  input  logic        sram_parity_error
);

  state_t      state;
  logic        rr_last;
  logic        id_q;
  logic        write_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] capture_q;
  logic [3:0]  parity;

  logic        win_id;
  logic        grant;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_in_range;
  logic        rsp_taken;

  // On a tie the master that did not win last time goes next.
  assign win_id       = (m0_req_valid & m1_req_valid) ? ~rr_last : m1_req_valid;
  assign grant        = (state == IDLE) & (m0_req_valid | m1_req_valid) & ~reset;
  assign m0_req_ready = grant & (win_id == M_FETCH);
  assign m1_req_ready = grant & (win_id == M_LSU);

  assign sel_write    = (win_id == M_LSU) ? m1_req_write : m0_req_write;
  assign sel_addr     = (win_id == M_LSU) ? m1_req_addr  : m0_req_addr;
  assign sel_wdata    = (win_id == M_LSU) ? m1_req_wdata : m0_req_wdata;
  assign sel_in_range = (sel_addr >= BASE_ADDR) && (sel_addr <= LIMIT_ADDR);

  sram2_parity_gen u_parity_gen (
    .data   (wdata_q),
    .parity (parity)
  );

  // SRAM2 sees a real address only during ISSUE; reset kills an in-flight write strobe immediately.
  assign sram_address      = (state == ISSUE) ? addr_q : IDLE_ADDR;
  assign sram_write_enable = (state == ISSUE) & write_q & ~reset;
  assign sram_data_in      = (state == ISSUE) ? {parity, wdata_q} : 36'd0;

  assign m0_rsp_valid = (state == RESP) & (id_q == M_FETCH);
  assign m1_rsp_valid = (state == RESP) & (id_q == M_LSU);
  assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : 32'd0;
  assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : 32'd0;
  assign m0_rsp_err   = m0_rsp_valid & err_q;
  assign m1_rsp_err   = m1_rsp_valid & err_q;
  assign rsp_taken    = (id_q == M_LSU) ? m1_rsp_ready : m0_rsp_ready;

  // Read data is only valid in the high phase after the access edge, so grab it mid-cycle.
  always_ff @(negedge clock) begin
    if (state == CAPTURE) begin
      capture_q <= sram_data_out;
    end
  end

  // Sequencer: grant and latch, one SRAM access, then hold the response until taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rr_last <= M_LSU;
      id_q    <= M_FETCH;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            id_q    <= win_id;
            rr_last <= win_id;
            write_q <= sel_write;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            rdata_q <= 32'd0;
            if (sel_in_range) begin
              err_q <= 1'b0;
              state <= ISSUE;
            end else begin
              err_q <= 1'b1;
              state <= RESP;
            end
          end
        end
        ISSUE: begin
          if (write_q) begin
            err_q <= sram_parity_error;
            state <= RESP;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata_q <= capture_q;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_taken) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram2_arbiter.sv
// tb/tb_sram2_arbiter.sv - directed self-checking bench for sram2_arbiter
module tb_sram2_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req_valid, m0_req_ready, m0_req_write;
  logic [31:0] m0_req_addr, m0_req_wdata;
  logic        m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic [31:0] m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_write;
  logic [31:0] m1_req_addr, m1_req_wdata;
  logic        m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic [31:0] m1_rsp_rdata;
  logic        sram_write_enable;
  logic [31:0] sram_address;
  logic [35:0] sram_data_in;
  logic [31:0] sram_data_out;
  logic        sram_parity_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sram2_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_write(m0_req_write),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_write(m1_req_write),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .sram_write_enable(sram_write_enable), .sram_address(sram_address),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out),
    .sram_parity_error(sram_parity_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // SRAM2 model: word array, read data held for one cycle after the access edge, junk otherwise.
  logic [31:0] mem [0:8191];
  logic [31:0] rd_q = 32'hBAD0_BAD0;
  logic        force_perr;
  always @(posedge clock) begin
    if (sram_write_enable) mem[sram_address[14:2]] = sram_data_in[31:0];
    rd_q = (sram_address != 32'h0) ? mem[sram_address[14:2]] : 32'hBAD0_BAD0;
  end
  assign sram_data_out     = rd_q;
  assign sram_parity_error = force_perr;

  // Bus activity monitor.
  int          we_cnt = 0;
  int          addr_cnt = 0;
  logic [35:0] last_din = '0;
  logic [31:0] last_waddr = '0;
  always @(negedge clock) begin
    if (sram_write_enable === 1'b1) begin
      we_cnt = we_cnt + 1;
      last_din = sram_data_in;
      last_waddr = sram_address;
    end
    if (sram_address !== 32'h0) addr_cnt = addr_cnt + 1;
  end

  task automatic do_req(input bit m, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int acc);
    if (m) begin m1_req_valid = 1; m1_req_write = wr; m1_req_addr = a; m1_req_wdata = d; end
    else   begin m0_req_valid = 1; m0_req_write = wr; m0_req_addr = a; m0_req_wdata = d; end
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clock);
      if ((m ? m1_req_ready : m0_req_ready) === 1'b1) acc = cyc;
    end
    @(posedge clock); #1;
    if (m) m1_req_valid = 0; else m0_req_valid = 0;
    checks++;
    if (acc < 0) begin errors++; $display("FAIL req_accept m%0d: got no ready, expected ready within 20 cycles", m); end
  endtask

  task automatic wait_rsp(input bit m, input int acc, output int lat, output logic [31:0] rd,
                          output logic er);
    lat = -1; rd = '0; er = 1'b0;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clock);
      if ((m ? m1_rsp_valid : m0_rsp_valid) === 1'b1) begin
        lat = cyc - acc;
        rd  = m ? m1_rsp_rdata : m0_rsp_rdata;
        er  = m ? m1_rsp_err : m0_rsp_err;
      end
    end
    checks++;
    if (lat < 0) begin errors++; $display("FAIL rsp_wait m%0d: got no rsp_valid, expected one within 20 cycles", m); end
  endtask

  task automatic accept_rsp(input bit m);
    if (m) m1_rsp_ready = 1; else m0_rsp_ready = 1;
    @(posedge clock); #1;
    if (m) m1_rsp_ready = 0; else m0_rsp_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if ({m0_req_ready, m1_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {m0_req_ready, m1_req_ready}); end
    checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", {m0_rsp_valid, m1_rsp_valid}); end
    checks++; if ({m0_rsp_err, m1_rsp_err} !== 2'b00) begin errors++; $display("FAIL reset_rsp_err: got %b expected 00", {m0_rsp_err, m1_rsp_err}); end
    checks++; if ({m0_rsp_rdata, m1_rsp_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {m0_rsp_rdata, m1_rsp_rdata}); end
    checks++; if (sram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", sram_write_enable); end
    checks++; if (sram_address !== 32'h0) begin errors++; $display("FAIL reset_address: got %h expected 00000000", sram_address); end
    checks++; if (sram_data_in !== 36'h0) begin errors++; $display("FAIL reset_data_in: got %h expected 0", sram_data_in); end
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic test_read();
    int acc, lat; logic [31:0] rd; logic er;
    mem[4] = 32'hDEAD_BEEF;
    do_req(0, 0, 32'h1000_0010, 32'h0, acc);
    wait_rsp(0, acc, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL t1_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_rdata: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL t1_err: got %b expected 0", er); end
    accept_rsp(0);
  endtask

  task automatic test_write();
    int acc, lat, w0; logic [31:0] rd; logic er;
    w0 = we_cnt;
    do_req(1, 1, 32'h1000_0020, 32'h0102_0304, acc);
    wait_rsp(1, acc, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL t2_latency: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL t2_err: got %b expected 0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL t2_rdata: got %h expected 0", rd); end
    checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL t2_we_cycles: got %0d expected 1", we_cnt - w0); end
    // bytes 04,03,02,01 have odd,even,odd,odd popcount -> parity 4'b1101
    checks++; if (last_din !== 36'hD_0102_0304) begin errors++; $display("FAIL t2_data_in: got %h expected d01020304", last_din); end
    checks++; if (last_waddr !== 32'h1000_0020) begin errors++; $display("FAIL t2_address: got %h expected 10000020", last_waddr); end
    accept_rsp(1);
    do_req(1, 0, 32'h1000_0020, 32'h0, acc);
    wait_rsp(1, acc, lat, rd, er);
    checks++; if (rd !== 32'h0102_0304) begin errors++; $display("FAIL t2_readback: got %h expected 01020304", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL t2_read_latency: got %0d expected 3", lat); end
    accept_rsp(1);
  endtask

  task automatic test_contention();
    int order[8]; int n = 0, g0 = 0, g1 = 0, r0 = 0, r1 = 0;
    for (int k = 0; k < 4; k++) begin
      mem[32'h40 + k] = 32'hA000_0000 + 32'(k);
      mem[32'h80 + k] = 32'hB000_0000 + 32'(k);
    end
    reset = 1; @(posedge clock); #1; reset = 0;
    m0_rsp_ready = 1; m1_rsp_ready = 1;
    m0_req_write = 0; m1_req_write = 0;
    m0_req_valid = 1; m0_req_addr = 32'h1000_0100;
    m1_req_valid = 1; m1_req_addr = 32'h1000_0200;
    for (int c = 0; c < 80 && (r0 < 4 || r1 < 4); c++) begin
      @(negedge clock);
      if (m0_req_ready === 1'b1) begin if (n < 8) order[n] = 0; n++; g0++; end
      if (m1_req_ready === 1'b1) begin if (n < 8) order[n] = 1; n++; g1++; end
      if (m0_rsp_valid === 1'b1) begin
        checks++; if (m0_rsp_rdata !== 32'hA000_0000 + 32'(r0)) begin errors++; $display("FAIL t3_m0_rdata%0d: got %h expected %h", r0, m0_rsp_rdata, 32'hA000_0000 + 32'(r0)); end
        r0++;
      end
      if (m1_rsp_valid === 1'b1) begin
        checks++; if (m1_rsp_rdata !== 32'hB000_0000 + 32'(r1)) begin errors++; $display("FAIL t3_m1_rdata%0d: got %h expected %h", r1, m1_rsp_rdata, 32'hB000_0000 + 32'(r1)); end
        r1++;
      end
      @(posedge clock); #1;
      m0_req_valid = (g0 < 4); m0_req_addr = 32'h1000_0100 + 32'(4 * g0);
      m1_req_valid = (g1 < 4); m1_req_addr = 32'h1000_0200 + 32'(4 * g1);
    end
    m0_req_valid = 0; m1_req_valid = 0; m0_rsp_ready = 0; m1_rsp_ready = 0;
    checks++; if (n !== 8) begin errors++; $display("FAIL t3_grant_count: got %0d expected 8", n); end
    checks++; if (r0 !== 4 || r1 !== 4) begin errors++; $display("FAIL t3_rsp_count: got %0d/%0d expected 4/4", r0, r1); end
    for (int i = 0; i < 8 && i < n; i++) begin
      checks++; if (order[i] !== i % 2) begin errors++; $display("FAIL t3_order%0d: got M%0d expected M%0d", i, order[i], i % 2); end
    end
  endtask

  task automatic test_range();
    int acc, lat, a0, w0; logic [31:0] rd; logic er;
    a0 = addr_cnt; w0 = we_cnt;
    do_req(1, 0, 32'h1000_8000, 32'h0, acc);
    wait_rsp(1, acc, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL t4_hi_latency: got %0d expected 1", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL t4_hi_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL t4_hi_rdata: got %h expected 0", rd); end
    checks++; if (addr_cnt !== a0) begin errors++; $display("FAIL t4_hi_address_moved: got %0d cycles expected 0", addr_cnt - a0); end
    checks++; if (we_cnt !== w0) begin errors++; $display("FAIL t4_hi_we: got %0d cycles expected 0", we_cnt - w0); end
    accept_rsp(1);
    do_req(1, 1, 32'h0FFF_FFFF, 32'h1234_5678, acc);
    wait_rsp(1, acc, lat, rd, er);
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL t4_lo: got err=%b lat=%0d expected err=1 lat=1", er, lat); end
    checks++; if (we_cnt !== w0) begin errors++; $display("FAIL t4_lo_we: got %0d cycles expected 0", we_cnt - w0); end
    accept_rsp(1);
    mem[13'h1FFF] = 32'hCAFE_0001;
    do_req(1, 0, 32'h1000_7FFF, 32'h0, acc);
    wait_rsp(1, acc, lat, rd, er);
    checks++; if (rd !== 32'hCAFE_0001) begin errors++; $display("FAIL t4_edge_rdata: got %h expected cafe0001", rd); end
    checks++; if (er !== 1'b0 || lat !== 3) begin errors++; $display("FAIL t4_edge: got err=%b lat=%0d expected err=0 lat=3", er, lat); end
    accept_rsp(1);
  endtask

  task automatic test_parity_hold();
    int acc, lat, unstable = 0, grants = 0; logic [31:0] rd; logic er;
    force_perr = 1;
    do_req(0, 1, 32'h1000_0044, 32'h0000_0055, acc);
    wait_rsp(0, acc, lat, rd, er);
    force_perr = 0;
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL t5_perr: got %b expected 1", er); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL t5_latency: got %0d expected 2", lat); end
    m1_req_valid = 1; m1_req_write = 0; m1_req_addr = 32'h1000_0048;
    repeat (5) begin
      @(negedge clock);
      if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'h0 || m0_rsp_err !== 1'b1) unstable++;
      if (m1_req_ready !== 1'b0 || m0_req_ready !== 1'b0) grants++;
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL t5_hold_stable: got %0d unstable cycles expected 0", unstable); end
    checks++; if (grants !== 0) begin errors++; $display("FAIL t5_no_grant: got %0d grant cycles expected 0", grants); end
    m1_req_valid = 0;
    accept_rsp(0);
  endtask

  task automatic test_reset_issue();
    int acc, lat, w0; logic [31:0] rd; logic er;
    mem[16] = 32'h1111_2222;
    w0 = we_cnt;
    do_req(0, 1, 32'h1000_0040, 32'hFFFF_0000, acc);
    reset = 1;
    m0_req_valid = 1; m0_req_write = 0; m0_req_addr = 32'h1000_0040;
    @(negedge clock);
    checks++; if (sram_write_enable !== 1'b0) begin errors++; $display("FAIL t6_we_gated: got %b expected 0", sram_write_enable); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (m0_req_ready !== 1'b0) begin errors++; $display("FAIL t6_ready_in_reset: got %b expected 0", m0_req_ready); end
    checks++; if (m0_rsp_valid !== 1'b0) begin errors++; $display("FAIL t6_no_rsp: got %b expected 0", m0_rsp_valid); end
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    checks++; if (m0_req_ready !== 1'b1) begin errors++; $display("FAIL t6_idle_after_reset: got ready=%b expected 1", m0_req_ready); end
    acc = cyc;
    @(posedge clock); #1;
    m0_req_valid = 0;
    wait_rsp(0, acc, lat, rd, er);
    checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL t6_location: got %h expected 11112222", rd); end
    checks++; if (we_cnt !== w0) begin errors++; $display("FAIL t6_we_count: got %0d cycles expected 0", we_cnt - w0); end
    checks++; if (mem[16] !== 32'h1111_2222) begin errors++; $display("FAIL t6_mem: got %h expected 11112222", mem[16]); end
    accept_rsp(0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1; force_perr = 0;
    m0_req_valid = 0; m0_req_write = 0; m0_req_addr = '0; m0_req_wdata = '0; m0_rsp_ready = 0;
    m1_req_valid = 0; m1_req_write = 0; m1_req_addr = '0; m1_req_wdata = '0; m1_rsp_ready = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_range();
    test_parity_hold();
    test_reset_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
